// File: rtl/cache_pkg.sv
// Shared defaults, derived-width helpers and the controller state encoding
// for the set-associative tag store with true-LRU replacement.
package cache_pkg;

   localparam int ADDR_W_DEF   = 12;
   localparam int OFFSET_W_DEF = 4;
   localparam int SETS_DEF     = 8;
   localparam int WAYS_DEF     = 4;

   function automatic int index_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int way_w(input int ways);
      return $clog2(ways);
   endfunction

   function automatic int tag_w(input int addr_w, input int offset_w, input int sets);
      return addr_w - offset_w - $clog2(sets);
   endfunction

   typedef enum logic [1:0] {
      FLUSH,
      IDLE,
      LOOKUP,
      RESP
   } state_t;

endpackage

// File: rtl/cache_lru_update.sv
// Combinational true-LRU age update: the accessed way becomes MRU (age 0) and
// every way younger than it ages by one, so the set stays a permutation.
module cache_lru_update
   import cache_pkg::*;
#(
   parameter int WAYS  = WAYS_DEF,
   parameter int WAY_W = way_w(WAYS)
)(
   input  logic [WAYS-1:0][WAY_W-1:0] i_age,
   input  logic [WAY_W-1:0]           i_way,
   output logic [WAYS-1:0][WAY_W-1:0] o_age
);

   logic [WAY_W-1:0] w_acc_age;

   always_comb begin
      o_age     = '0;
      w_acc_age = i_age[i_way];
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (WAY_W'(w) == i_way)
            o_age[w] = '0;
         else if (i_age[w] < w_acc_age)
            o_age[w] = i_age[w] + 1'b1;
         else
            o_age[w] = i_age[w];
      end
   end

endmodule

// File: rtl/cache_tag_lru.sv
// Tag store with LRU allocation: one lookup per three cycles, a registered
// single-cycle response, and a one-set-per-cycle invalidate sweep on reset/flush.
module cache_tag_lru
   import cache_pkg::*;
#(
   parameter  int ADDR_W   = ADDR_W_DEF,
   parameter  int OFFSET_W = OFFSET_W_DEF,
   parameter  int SETS     = SETS_DEF,
   parameter  int WAYS     = WAYS_DEF,
   localparam int INDEX_W  = index_w(SETS),
   localparam int WAY_W    = way_w(WAYS),
   localparam int TAG_W    = tag_w(ADDR_W, OFFSET_W, SETS)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              flush,
   output logic              busy,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [WAY_W-1:0]  resp_way,
   output logic              resp_victim_valid,
   output logic [TAG_W-1:0]  resp_victim_tag
);

   state_t                       r_state;
   logic [INDEX_W-1:0]           r_cnt;
   logic [INDEX_W-1:0]           r_req_idx;
   logic [TAG_W-1:0]             r_req_tag;
   logic                         r_resp_valid;
   logic                         r_resp_hit;
   logic [WAY_W-1:0]             r_resp_way;
   logic                         r_resp_vv;
   logic [TAG_W-1:0]             r_resp_vtag;

   logic [WAYS-1:0]              r_valid_mem [SETS];
   logic [WAYS-1:0][TAG_W-1:0]   r_tag_mem   [SETS];
   logic [WAYS-1:0][WAY_W-1:0]   r_age_mem   [SETS];

   logic [WAYS-1:0]              w_set_valid;
   logic [WAYS-1:0][TAG_W-1:0]   w_set_tag;
   logic [WAYS-1:0][WAY_W-1:0]   w_set_age;
   logic [WAYS-1:0][WAY_W-1:0]   w_age_new;
   logic                         w_hit;
   logic [WAY_W-1:0]             w_hit_way;
   logic                         w_inv_found;
   logic [WAY_W-1:0]             w_inv_way;
   logic [WAY_W-1:0]             w_lru_way;
   logic [WAY_W-1:0]             w_sel_way;
   logic                         w_victim_valid;
   logic [TAG_W-1:0]             w_victim_tag;
   logic                         w_unused_offset;

   assign w_unused_offset = ^req_addr[OFFSET_W-1:0];

   assign busy              = (r_state == FLUSH);
   assign req_ready         = (r_state == IDLE) && !flush;
   assign resp_valid        = r_resp_valid;
   assign resp_hit          = r_resp_hit;
   assign resp_way          = r_resp_way;
   assign resp_victim_valid = r_resp_vv;
   assign resp_victim_tag   = r_resp_vtag;

   // The addressed set is held stable from LOOKUP through RESP, so the same
   // read feeds both the compare and the closing-edge age update.
   assign w_set_valid = r_valid_mem[r_req_idx];
   assign w_set_tag   = r_tag_mem[r_req_idx];
   assign w_set_age   = r_age_mem[r_req_idx];

   always_comb begin
      w_hit       = 1'b0;
      w_hit_way   = '0;
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      w_lru_way   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (w_set_valid[w] && (w_set_tag[w] == r_req_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
         if (!w_set_valid[w] && !w_inv_found) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(w);
         end
         if (w_set_age[w] == WAY_W'(WAYS - 1))
            w_lru_way = WAY_W'(w);
      end
      w_sel_way      = w_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_lru_way);
      w_victim_valid = !w_hit && w_set_valid[w_sel_way];
      w_victim_tag   = w_victim_valid ? w_set_tag[w_sel_way] : '0;
   end

   cache_lru_update #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_lru (
      .i_age (w_set_age),
      .i_way (r_resp_way),
      .o_age (w_age_new)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= FLUSH;
         r_cnt        <= '0;
         r_req_idx    <= '0;
         r_req_tag    <= '0;
         r_resp_valid <= 1'b0;
         r_resp_hit   <= 1'b0;
         r_resp_way   <= '0;
         r_resp_vv    <= 1'b0;
         r_resp_vtag  <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_hit   <= 1'b0;
         r_resp_way   <= '0;
         r_resp_vv    <= 1'b0;
         r_resp_vtag  <= '0;
         case (r_state)
            FLUSH: begin
               r_valid_mem[r_cnt] <= '0;
               for (int unsigned w = 0; w < WAYS; w++)
                  r_age_mem[r_cnt][w] <= WAY_W'(w);
               if (r_cnt == INDEX_W'(SETS - 1))
                  r_state <= IDLE;
               else
                  r_cnt <= r_cnt + 1'b1;
            end
            IDLE: begin
               if (flush) begin
                  r_state <= FLUSH;
                  r_cnt   <= '0;
               end else if (req_valid) begin
                  r_req_idx <= req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
                  r_req_tag <= req_addr[ADDR_W-1:OFFSET_W+INDEX_W];
                  r_state   <= LOOKUP;
               end
            end
            LOOKUP: begin
               r_resp_valid <= 1'b1;
               r_resp_hit   <= w_hit;
               r_resp_way   <= w_sel_way;
               r_resp_vv    <= w_victim_valid;
               r_resp_vtag  <= w_victim_tag;
               r_state      <= RESP;
            end
            RESP: begin
               r_age_mem[r_req_idx] <= w_age_new;
               if (!r_resp_hit) begin
                  r_valid_mem[r_req_idx][r_resp_way] <= 1'b1;
                  r_tag_mem[r_req_idx][r_resp_way]   <= r_req_tag;
               end
               r_state <= IDLE;
            end
            default: r_state <= FLUSH;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_tag_lru.sv
// Directed bench for cache_tag_lru at default geometry (12-bit address,
// 8 sets, 4 ways); set 2 addresses 0x020/0x0A0/0x120/0x1A0/0x220/0x2A0 = tags 0..5.
module tb_cache_tag_lru;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [11:0] req_addr = '0;
   logic        flush = 1'b0;
   logic        req_ready;
   logic        busy;
   logic        resp_valid;
   logic        resp_hit;
   logic [1:0]  resp_way;
   logic        resp_victim_valid;
   logic [4:0]  resp_victim_tag;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cache_tag_lru #(
      .ADDR_W   (12),
      .OFFSET_W (4),
      .SETS     (8),
      .WAYS     (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_addr          (req_addr),
      .flush             (flush),
      .busy              (busy),
      .resp_valid        (resp_valid),
      .resp_hit          (resp_hit),
      .resp_way          (resp_way),
      .resp_victim_valid (resp_victim_valid),
      .resp_victim_tag   (resp_victim_tag)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required <200000", $time);
      $fatal(1);
   end

   // Issues one request and waits for its response; lat counts edges from the accepting edge.
   task automatic do_req(input logic [11:0] a, output logic got, output int lat,
                         output logic h, output logic [1:0] w, output logic vv,
                         output logic [4:0] vt);
      int n;
      got = 1'b0; lat = 0; n = 0; h = 1'b0; w = '0; vv = 1'b0; vt = '0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      req_valid = 1'b1;
      req_addr  = a;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 10) begin
         @(posedge clk); #1; lat++;
      end
      if (resp_valid) begin
         got = 1'b1;
         h = resp_hit; w = resp_way; vv = resp_victim_valid; vt = resp_victim_tag;
      end
      @(posedge clk); #1;
   endtask

   task automatic reset_and_sweep();
      int n;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n = 0;
      while (busy && n < 50) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_hit !== 1'b0 ||
          resp_way !== 2'd0 || resp_victim_valid !== 1'b0 || resp_victim_tag !== 5'd0) begin
         miscompares++;
         $display("FAIL reset_state: busy=%0b ready=%0b rv=%0b hit=%0b way=%0d vv=%0b vt=%0d, required busy=1 ready=0 rest 0",
                  busy, req_ready, resp_valid, resp_hit, resp_way, resp_victim_valid, resp_victim_tag);
      end
      rst = 1'b0;
      n = 0;
      while (busy && n < 50) begin
         n++; @(posedge clk); #1;
      end
      vectors++;
      if (n !== 8) begin
         miscompares++;
         $display("FAIL reset_sweep_len: busy cycles=%0d, required 8", n);
      end
      vectors++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: ready=%0b busy=%0b, required ready=1 busy=0", req_ready, busy);
      end
   endtask

   task automatic test_basic();
      logic got, h, vv; int lat; logic [1:0] w; logic [4:0] vt;
      do_req(12'h123, got, lat, h, w, vv, vt);
      vectors++;
      if (!got || lat !== 2 || h !== 1'b0 || w !== 2'd0 || vv !== 1'b0 || vt !== 5'd0) begin
         miscompares++;
         $display("FAIL basic_miss: got=%0b lat=%0d hit=%0b way=%0d vv=%0b vt=%0d, required got=1 lat=2 hit=0 way=0 vv=0 vt=0",
                  got, lat, h, w, vv, vt);
      end
      vectors++;
      if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_way !== 2'd0 ||
          resp_victim_valid !== 1'b0 || resp_victim_tag !== 5'd0) begin
         miscompares++;
         $display("FAIL idle_outputs: rv=%0b hit=%0b way=%0d vv=%0b vt=%0d, required all 0",
                  resp_valid, resp_hit, resp_way, resp_victim_valid, resp_victim_tag);
      end
      do_req(12'h123, got, lat, h, w, vv, vt);
      vectors++;
      if (!got || lat !== 2 || h !== 1'b1 || w !== 2'd0 || vv !== 1'b0 || vt !== 5'd0) begin
         miscompares++;
         $display("FAIL basic_hit: got=%0b lat=%0d hit=%0b way=%0d vv=%0b vt=%0d, required got=1 lat=2 hit=1 way=0 vv=0 vt=0",
                  got, lat, h, w, vv, vt);
      end
   endtask

   task automatic test_fill_lru();
      logic [11:0] addr [7] = '{12'h020, 12'h0A0, 12'h120, 12'h1A0, 12'h020, 12'h220, 12'h2A0};
      logic        eh   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [1:0]  ew   [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
      logic        evv  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [4:0]  evt  [7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2};
      logic got, h, vv; int lat; logic [1:0] w; logic [4:0] vt;
      reset_and_sweep();
      for (int i = 0; i < 7; i++) begin
         do_req(addr[i], got, lat, h, w, vv, vt);
         vectors++;
         if (!got || lat !== 2 || h !== eh[i] || w !== ew[i] || vv !== evv[i] || vt !== evt[i]) begin
            miscompares++;
            $display("FAIL fill[%0d] addr=%h: got=%0b lat=%0d hit=%0b way=%0d vv=%0b vt=%0d, required lat=2 hit=%0b way=%0d vv=%0b vt=%0d",
                     i, addr[i], got, lat, h, w, vv, vt, eh[i], ew[i], evv[i], evt[i]);
         end
      end
   endtask

   task automatic test_flush();
      logic got, h, vv; int lat; logic [1:0] w; logic [4:0] vt; int n;
      flush = 1'b1;
      #1;
      vectors++;
      if (req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_ready: ready=%0b, required 0", req_ready);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      n = 0;
      while (busy && n < 50) begin
         n++; @(posedge clk); #1;
      end
      vectors++;
      if (n !== 8) begin
         miscompares++;
         $display("FAIL flush_sweep_len: busy cycles=%0d, required 8", n);
      end
      do_req(12'h0A0, got, lat, h, w, vv, vt);
      vectors++;
      if (!got || lat !== 2 || h !== 1'b0 || w !== 2'd0 || vv !== 1'b0 || vt !== 5'd0) begin
         miscompares++;
         $display("FAIL after_flush: got=%0b lat=%0d hit=%0b way=%0d vv=%0b vt=%0d, required lat=2 hit=0 way=0 vv=0 vt=0",
                  got, lat, h, w, vv, vt);
      end
   endtask

   task automatic test_flush_collision();
      int n; logic seen;
      flush = 1'b1; req_valid = 1'b1; req_addr = 12'h1A0;
      #1;
      vectors++;
      if (req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL collide_ready: ready=%0b, required 0", req_ready);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      n = 0; seen = 1'b0;
      while (busy && n < 50) begin
         n++;
         if (resp_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      vectors++;
      if (n !== 8 || seen !== 1'b0) begin
         miscompares++;
         $display("FAIL collide_sweep: busy cycles=%0d resp_seen=%0b, required 8 and 0", n, seen);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      vectors++;
      if (resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL collide_lookup: rv=%0b, required 0", resp_valid);
      end
      @(posedge clk); #1;
      vectors++;
      if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || resp_way !== 2'd0 || resp_victim_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL collide_resp: rv=%0b hit=%0b way=%0d vv=%0b, required rv=1 hit=0 way=0 vv=0",
                  resp_valid, resp_hit, resp_way, resp_victim_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [11:0] addrs [4] = '{12'h020, 12'h0A0, 12'h120, 12'h1A0};
      logic hs, done, seen, got, h, vv; int k, pulses, n, lat;
      int       t [2];
      logic     ph [2];
      logic [1:0] pw [2];
      logic [1:0] w; logic [4:0] vt;
      k = 0; pulses = 0; done = 1'b0;
      t[0] = 0; t[1] = 0; ph[0] = 1'b1; ph[1] = 1'b1; pw[0] = '0; pw[1] = '0;
      req_valid = 1'b1; req_addr = addrs[0];
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         hs = req_valid && req_ready;
         @(posedge clk); #1;
         if (resp_valid) begin
            if (pulses < 2) begin
               t[pulses] = cyc; ph[pulses] = resp_hit; pw[pulses] = resp_way;
            end
            pulses++;
         end
         if (hs) begin
            k++;
            if (k < 4) req_addr = addrs[k];
            if (k == 3) begin
               rst = 1'b1; req_valid = 1'b0; done = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      n = 0; seen = 1'b0;
      while (busy && n < 50) begin
         n++;
         if (resp_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      vectors++;
      if (pulses !== 2 || t[1] - t[0] !== 3) begin
         miscompares++;
         $display("FAIL b2b_pulses: pulses=%0d spacing=%0d, required 2 and 3", pulses, t[1] - t[0]);
      end
      vectors++;
      if (ph[0] !== 1'b0 || pw[0] !== 2'd1 || ph[1] !== 1'b0 || pw[1] !== 2'd2) begin
         miscompares++;
         $display("FAIL b2b_results: hit0=%0b way0=%0d hit1=%0b way1=%0d, required 0/1 and 0/2",
                  ph[0], pw[0], ph[1], pw[1]);
      end
      vectors++;
      if (n !== 8 || seen !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_abort_sweep: busy cycles=%0d resp_seen=%0b, required 8 and 0", n, seen);
      end
      do_req(12'h1A0, got, lat, h, w, vv, vt);
      vectors++;
      if (!got || h !== 1'b0 || w !== 2'd0 || vv !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_cleared: got=%0b hit=%0b way=%0d vv=%0b, required got=1 hit=0 way=0 vv=0",
                  got, h, w, vv);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill_lru();
      test_flush();
      test_flush_collision();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
